// File: rtl/mem_port_arbiter_if.sv
// Bundle of every non-clock/reset signal of mem_port_arbiter.
//  slave  : the arbiter's view (requests and memory responses in, grants/responses and
//           the registered memory request out).
//  master : the surrounding environment's view (core ports plus memory model).
// Signal groups:
//  if_*   fetch port   : req/addr in, gnt/rvalid/rdata out
//  dm_*   data port    : req/we/be/addr/wdata in, gnt/rvalid/rdata out
//  mem_*  memory side  : req/we/be/addr/wdata out, gnt/rvalid/rdata in
//  busy_o              : arbiter not idle
interface mem_port_arbiter_if #(
   parameter int XLEN = 32
);
   logic                if_req_i;
   logic [XLEN-1:0]     if_addr_i;
   logic                if_gnt_o;
   logic                if_rvalid_o;
   logic [XLEN-1:0]     if_rdata_o;

   logic                dm_req_i;
   logic                dm_we_i;
   logic [XLEN/8-1:0]   dm_be_i;
   logic [XLEN-1:0]     dm_addr_i;
   logic [XLEN-1:0]     dm_wdata_i;
   logic                dm_gnt_o;
   logic                dm_rvalid_o;
   logic [XLEN-1:0]     dm_rdata_o;

   logic                mem_req_o;
   logic                mem_we_o;
   logic [XLEN/8-1:0]   mem_be_o;
   logic [XLEN-1:0]     mem_addr_o;
   logic [XLEN-1:0]     mem_wdata_o;
   logic                mem_gnt_i;
   logic                mem_rvalid_i;
   logic [XLEN-1:0]     mem_rdata_i;

   logic                busy_o;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
      output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output busy_o
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
      input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  busy_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//  Shares one single-port memory between the instruction-fetch port (IF) and the data
//  port (DM). One transaction outstanding at a time; DM has priority, but after
//  STARVE_LIMIT consecutive DM wins while IF was waiting, IF is forced to win.
//  The memory request/payload is registered, giving a cycle-exact memory trace.
// Ports:
//  clk  : clock, rising edge
//  rst  : asynchronous reset, active-high
//  bus  : mem_port_arbiter_if.slave (fetch port, data port, memory port, busy_o)
module mem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);
   localparam int BEW = XLEN / 8;
   localparam int SW  = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;      // 0 = IF, 1 = DM
   logic [SW-1:0]     starve_q, starve_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [BEW-1:0]    mem_be_q, mem_be_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

   logic arb_en;
   logic win_dm;
   logic win_if;
   logic gnt_fire;
   logic rsp_fire;

   // DM wins any contest unless IF has been passed over STARVE_LIMIT times in a row.
   assign win_dm = bus.dm_req_i && (!bus.if_req_i || (starve_q != STARVE_MAX));
   assign win_if = bus.if_req_i && !win_dm;

   assign gnt_fire = (state_q == ST_REQ) && bus.mem_gnt_i;
   assign rsp_fire = (state_q == ST_RSP) && bus.mem_rvalid_i;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      starve_d    = starve_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      arb_en      = 1'b0;

      case (state_q)
         ST_IDLE: arb_en = 1'b1;
         ST_REQ: begin
            if (bus.mem_gnt_i) begin
               mem_req_d = 1'b0;
               state_d   = ST_RSP;
            end
         end
         ST_RSP: begin
            // Response closes the transaction; the same cycle may launch the next one.
            if (bus.mem_rvalid_i) begin
               arb_en  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (arb_en && (win_dm || win_if)) begin
         state_d   = ST_REQ;
         mem_req_d = 1'b1;
         owner_d   = win_dm;
         if (win_dm) begin
            mem_we_d    = bus.dm_we_i;
            mem_be_d    = bus.dm_be_i;
            mem_addr_d  = bus.dm_addr_i;
            mem_wdata_d = bus.dm_wdata_i;
            if (bus.if_req_i && (starve_q != STARVE_MAX)) begin
               starve_d = starve_q + 1'b1;
            end
         end else begin
            mem_we_d    = 1'b0;
            mem_be_d    = {BEW{1'b1}};
            mem_addr_d  = bus.if_addr_i;
            mem_wdata_d = '0;
            starve_d    = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         starve_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_be_o    = mem_be_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;

   // Grant and response pulses are steered to whichever port owns the transaction.
   assign bus.if_gnt_o    = gnt_fire && !owner_q;
   assign bus.dm_gnt_o    = gnt_fire &&  owner_q;
   assign bus.if_rvalid_o = rsp_fire && !owner_q;
   assign bus.dm_rvalid_o = rsp_fire &&  owner_q;
   assign bus.if_rdata_o  = bus.mem_rdata_i;
   assign bus.dm_rdata_o  = bus.mem_rdata_i;

   assign bus.busy_o = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_port_arbiter_if #(.XLEN(32)) bus ();

   mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_dm;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          gnt_dly;
      int          rv_dly;
      logic [31:0] rdata;
      logic        exp_we;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drop_reqs();
      bus.if_req_i = 1'b0;
      bus.dm_req_i = 1'b0;
   endtask

   // One complete transaction from IDLE, checked cycle by cycle.
   task automatic run_vec(input vec_t v, input int idx);
      string t;
      t = $sformatf("v%0d", idx);
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      if (v.is_dm) begin
         bus.dm_req_i   = 1'b1;
         bus.dm_we_i    = v.we;
         bus.dm_be_i    = v.be;
         bus.dm_addr_i  = v.addr;
         bus.dm_wdata_i = v.wdata;
         bus.if_req_i   = 1'b0;
         bus.if_addr_i  = 32'h5555_5555;
      end else begin
         bus.if_req_i   = 1'b1;
         bus.if_addr_i  = v.addr;
         bus.dm_req_i   = 1'b0;
         bus.dm_we_i    = 1'b1;
         bus.dm_be_i    = 4'h0;
         bus.dm_addr_i  = 32'hAAAA_AAAA;
         bus.dm_wdata_i = 32'hFFFF_FFFF;
      end
      #1 check({t, " busy_before"}, 32'(bus.busy_o), 32'd0);
      step();
      for (int c = 0; c <= v.gnt_dly; c++) begin
         bus.mem_gnt_i = (c == v.gnt_dly);
         #1;
         check({t, " mem_req"},   32'(bus.mem_req_o), 32'd1);
         check({t, " mem_addr"},  bus.mem_addr_o, v.addr);
         check({t, " mem_we"},    32'(bus.mem_we_o), 32'(v.exp_we));
         check({t, " mem_be"},    32'(bus.mem_be_o), 32'(v.exp_be));
         check({t, " mem_wdata"}, bus.mem_wdata_o, v.exp_wdata);
         check({t, " own_gnt"},   32'(v.is_dm ? bus.dm_gnt_o : bus.if_gnt_o), 32'(c == v.gnt_dly));
         check({t, " other_gnt"}, 32'(v.is_dm ? bus.if_gnt_o : bus.dm_gnt_o), 32'd0);
         step();
      end
      bus.mem_gnt_i = 1'b0;
      drop_reqs();
      for (int c = 0; c <= v.rv_dly; c++) begin
         bus.mem_rvalid_i = (c == v.rv_dly);
         bus.mem_rdata_i  = (c == v.rv_dly) ? v.rdata : 32'hBAD0_0000 + 32'(c);
         #1;
         check({t, " mem_req_rsp"}, 32'(bus.mem_req_o), 32'd0);
         check({t, " own_rvalid"},  32'(v.is_dm ? bus.dm_rvalid_o : bus.if_rvalid_o), 32'(c == v.rv_dly));
         check({t, " other_rvalid"}, 32'(v.is_dm ? bus.if_rvalid_o : bus.dm_rvalid_o), 32'd0);
         if (c == v.rv_dly)
            check({t, " rdata"}, v.is_dm ? bus.dm_rdata_o : bus.if_rdata_o, v.rdata);
         step();
      end
      bus.mem_rvalid_i = 1'b0;
      #1 check({t, " busy_after"}, 32'(bus.busy_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic pattern [6];
      vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h8000_0000, 32'h0, 0, 0, 32'h0000_006F, 1'b0, 4'hF, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 4'b0010, 32'h0000_1001, 32'h0000_AB00, 0, 1, 32'h0, 1'b1, 4'b0010, 32'h0000_AB00};
      vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'hDEAD_BEEF, 5, 2, 32'h1234_5678, 1'b0, 4'hF, 32'hDEAD_BEEF};
      vecs[3] = '{1'b0, 1'b0, 4'hF, 32'h8000_0004, 32'h0, 2, 0, 32'h0000_0013, 1'b0, 4'hF, 32'h0};
      vecs[4] = '{1'b1, 1'b1, 4'hF, 32'h0000_3000, 32'hCAFE_F00D, 1, 0, 32'h0, 1'b1, 4'hF, 32'hCAFE_F00D};
      pattern = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      // Reset with a pending DM request
      bus.if_req_i = 0; bus.if_addr_i = 0;
      bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_be_i = 4'hC;
      bus.dm_addr_i = 32'h0000_1234; bus.dm_wdata_i = 32'h0000_0055;
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
      @(negedge clk); @(negedge clk);
      #1;
      check("rst mem_req",   32'(bus.mem_req_o), 32'd0);
      check("rst mem_we",    32'(bus.mem_we_o), 32'd0);
      check("rst mem_be",    32'(bus.mem_be_o), 32'd0);
      check("rst mem_addr",  bus.mem_addr_o, 32'd0);
      check("rst mem_wdata", bus.mem_wdata_o, 32'd0);
      check("rst busy",      32'(bus.busy_o), 32'd0);
      check("rst gnts",      32'({bus.if_gnt_o, bus.dm_gnt_o}), 32'd0);
      check("rst rvalids",   32'({bus.if_rvalid_o, bus.dm_rvalid_o}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();
      #1;
      check("post_rst mem_req",   32'(bus.mem_req_o), 32'd1);
      check("post_rst mem_addr",  bus.mem_addr_o, 32'h0000_1234);
      check("post_rst mem_be",    32'(bus.mem_be_o), 32'hC);
      check("post_rst mem_wdata", bus.mem_wdata_o, 32'h0000_0055);
      bus.mem_gnt_i = 1;
      #1 check("post_rst dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
      step();
      drop_reqs();
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1;
      #1 check("post_rst dm_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
      step();
      bus.mem_rvalid_i = 0;
      #1 check("post_rst idle", 32'(bus.busy_o), 32'd0);

      // Table-driven single transactions
      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i], i);
         $display("vector %0d done: dm=%0d addr=0x%08h", i, vecs[i].is_dm, vecs[i].addr);
      end

      // Reset while waiting for a response, then a stray response
      bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0100;
      step();
      bus.mem_gnt_i = 1;
      #1 check("rsprst if_gnt", 32'(bus.if_gnt_o), 32'd1);
      step();
      drop_reqs();
      bus.mem_gnt_i = 0;
      rst = 1'b1;
      #1;
      check("rsprst busy",    32'(bus.busy_o), 32'd0);
      check("rsprst mem_req", 32'(bus.mem_req_o), 32'd0);
      step();
      rst = 1'b0;
      bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1111_2222;
      #1;
      check("stray if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
      check("stray dm_rvalid", 32'(bus.dm_rvalid_o), 32'd0);
      step();
      bus.mem_rvalid_i = 0;
      #1;
      check("stray busy",    32'(bus.busy_o), 32'd0);
      check("stray mem_req", 32'(bus.mem_req_o), 32'd0);
      $display("reset-in-RSP sequence done");

      // Both ports requesting continuously: DM x4 then IF, back-to-back
      bus.if_req_i = 1; bus.if_addr_i = 32'h0000_0100;
      bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_be_i = 4'hF;
      bus.dm_addr_i = 32'h0000_0200; bus.dm_wdata_i = 0;
      bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h77;
      step();
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("starve%0d mem_req", i),  32'(bus.mem_req_o), 32'd1);
         check($sformatf("starve%0d mem_addr", i), bus.mem_addr_o,
               pattern[i] ? 32'h0000_0200 : 32'h0000_0100);
         check($sformatf("starve%0d dm_gnt", i), 32'(bus.dm_gnt_o), 32'(pattern[i]));
         check($sformatf("starve%0d if_gnt", i), 32'(bus.if_gnt_o), 32'(!pattern[i]));
         step();
         if (i == 5) drop_reqs();
         #1;
         check($sformatf("starve%0d dm_rvalid", i), 32'(bus.dm_rvalid_o), 32'(pattern[i]));
         check($sformatf("starve%0d if_rvalid", i), 32'(bus.if_rvalid_o), 32'(!pattern[i]));
         $display("grant %0d to %s", i, bus.dm_rvalid_o ? "DM" : "IF");
         step();
      end
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;
      #1 check("starve idle", 32'(bus.busy_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
